// File: rtl/uart_tx_stream.sv
// uart_tx_stream
//   FIFO-buffered UART transmitter. Bytes pushed by on-chip producers are
//   queued in a circular buffer and serialised LSB first onto tx_out with
//   no idle gap between consecutive frames.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> parity_odd port exists, a parity bit follows the data bits
//     undefined -> frame is start + data + stop only
//
//   Parameters
//     DEPTH      FIFO entries (power of two, 2..256)
//     DATA_BITS  data bits per frame (5..8)
//     STOP_BITS  stop bits per frame (1 or 2)
//
//   Ports
//     clk         system clock
//     reset_n     asynchronous active-low reset
//     baud_div    clock cycles per bit (0 and 1 behave as 2), sampled per frame
//     wr_en       push wr_data this cycle
//     wr_data     byte to queue, bits above DATA_BITS-1 ignored
//     parity_odd  1 = odd parity, 0 = even (UART_TX_PARITY_EN only)
//     full        FIFO holds DEPTH entries
//     empty       FIFO holds no entries
//     level       FIFO occupancy
//     overflow    one-cycle pulse when a write was dropped
//     tx_out      serial line, idle high
//     tx_busy     frame in progress
//     tx_done     one-cycle pulse in the last cycle of the final stop bit
module uart_tx_stream #(
    parameter int DEPTH     = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [15:0]             baud_div,
    input  logic                    wr_en,
    input  logic [7:0]              wr_data,
`ifdef UART_TX_PARITY_EN
    input  logic                    parity_odd,
`endif
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    tx_out,
    output logic                    tx_busy,
    output logic                    tx_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Divider values below 2 cannot give a meaningful bit period.
    function automatic logic [15:0] sat_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 wr_accept;
    logic                 pop;

    state_t               state;
    state_t               state_nxt;
    logic [15:0]          timer;
    logic [15:0]          div_lat;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 bit_end;
    logic                 line_d;
    logic                 busy_d;
    logic                 done_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_acc;
`endif

    logic                 unused_wr_data;
    assign unused_wr_data = ^wr_data;

    // ---------------- FIFO ----------------
    // full is taken from the pointers before this cycle's pop, so a write
    // that arrives while full is dropped even if a pop happens alongside it.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level     = wr_ptr - rd_ptr;
    assign wr_accept = wr_en & ~full;
    assign head      = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= wr_data[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            overflow <= wr_en & full;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign bit_end = (timer == 16'd0);

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && bit_cnt == LAST_DATA) begin
                    state_nxt = PAR_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end && bit_cnt == LAST_STOP) begin
                    // Chain straight into the next frame when data is waiting.
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        line_d = 1'b1;
        busy_d = (state != S_IDLE);
        done_d = 1'b0;
        case (state)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_d = par_acc ^ parity_odd;
`else
            S_PARITY: line_d = 1'b1;
`endif
            S_STOP:   done_d = bit_end && (bit_cnt == LAST_STOP);
            default:  line_d = 1'b1;
        endcase
    end

    // ---------------- bit timer / bit counter ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer   <= '0;
            bit_cnt <= '0;
        end else if (pop) begin
            timer   <= sat_div(baud_div) - 16'd1;
            bit_cnt <= '0;
        end else if (state != S_IDLE) begin
            if (bit_end) begin
                timer   <= div_lat - 16'd1;
                bit_cnt <= (state_nxt != state) ? 3'd0 : bit_cnt + 3'd1;
            end else begin
                timer <= timer - 16'd1;
            end
        end
    end

    // ---------------- frame data (no reset needed) ----------------
    always_ff @(posedge clk) begin
        if (pop) begin
            shift   <= head;
            div_lat <= sat_div(baud_div);
`ifdef UART_TX_PARITY_EN
            par_acc <= ^head;
`endif
        end else if (state == S_DATA && bit_end) begin
            shift <= shift >> 1;
        end
    end

    // ---------------- registered line outputs ----------------
    // One cycle behind the FSM so tx_out is glitch-free; tx_busy and tx_done
    // share the same delay so they line up with the bits on the wire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_out  <= line_d;
            tx_busy <= busy_d;
            tx_done <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [15:0] baud_div;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        parity_odd;
    logic        full, empty, overflow, tx_out, tx_busy, tx_done;
    logic [2:0]  level;

    logic [15:0] baud_n;
    logic        wr_en_n;
    logic [7:0]  wr_data_n;
    logic        n_full, n_empty, n_overflow, n_tx_out, n_tx_busy, n_tx_done;
    logic [4:0]  n_level;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    uart_tx_stream #(.DEPTH(4), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .reset_n(reset_n), .baud_div(baud_div),
        .wr_en(wr_en), .wr_data(wr_data),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx_stream #(.DEPTH(16), .DATA_BITS(7), .STOP_BITS(2)) dut_n (
        .clk(clk), .reset_n(reset_n), .baud_div(baud_n),
        .wr_en(wr_en_n), .wr_data(wr_data_n),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .full(n_full), .empty(n_empty), .level(n_level), .overflow(n_overflow),
        .tx_out(n_tx_out), .tx_busy(n_tx_busy), .tx_done(n_tx_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] sb_q[$];
    int         done_q[$];
    int         rx_cnt = 0;
    int         mon_b = 4;
    int         start_cyc = 0;
    int         ov_cnt = 0;
    int         last_busy_fall = 0;
    logic       busy_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_q.push_back(cyc);
        if (overflow === 1'b1) ov_cnt <= ov_cnt + 1;
        if (busy_prev === 1'b1 && tx_busy === 1'b0) last_busy_fall <= cyc;
        busy_prev <= tx_busy;
    end

    // Serial receiver for the main DUT: samples each bit at its centre and
    // compares the decoded byte with the head of the scoreboard.
    task automatic skip(input int n, inout logic ok);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (reset_n !== 1'b1) ok = 1'b0;
        end
    endtask

    always begin : monitor
        logic [7:0] got;
        logic       ok;
        logic       par;
        logic [7:0] exp;
        int         b;
        @(negedge clk);
        if (reset_n === 1'b1 && tx_out === 1'b0) begin
            b = mon_b;
            start_cyc = cyc;
            ok = 1'b1;
            got = '0;
            par = 1'b0;
            skip(b / 2, ok);
            if (ok) check("mon_start_bit", {31'd0, tx_out}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                skip(b, ok);
                if (ok) got[i] = tx_out;
            end
            if (PB == 1) begin
                skip(b, ok);
                if (ok) par = tx_out;
            end
            skip(b, ok);
            if (ok) begin
                check("mon_stop_bit", {31'd0, tx_out}, 32'd1);
                check("mon_sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    check("mon_data", {24'd0, got}, {24'd0, exp});
                    if (PB == 1) check("mon_parity", {31'd0, par}, {31'd0, ^exp ^ parity_odd});
                end
                rx_cnt++;
                skip(b - 1 - b / 2, ok);
            end
        end
    end

    task automatic wait_rx(input int n, input int budget);
        int lim = 0;
        while (rx_cnt < n && lim < budget) begin
            @(negedge clk);
            lim++;
        end
        check("wait_rx", rx_cnt, n);
    endtask

    task automatic narrow_frame(input logic [7:0] d);
        int w;
        int lim;
        wr_en_n = 1'b1; wr_data_n = d;
        @(negedge clk);
        wr_en_n = 1'b0;
        w = cyc;
        lim = 0;
        while (n_tx_out !== 1'b0 && lim < 10) begin @(negedge clk); lim++; end
        check("n_start_cyc", cyc, w + 2);
        repeat (2) @(negedge clk);
        check("n_start_bit", {31'd0, n_tx_out}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            repeat (4) @(negedge clk);
            check("n_data_bit", {31'd0, n_tx_out}, {31'd0, d[i]});
        end
        for (int i = 0; i < 2; i++) begin
            repeat (4) @(negedge clk);
            check("n_stop_bit", {31'd0, n_tx_out}, 32'd1);
        end
        lim = 0;
        while (n_tx_done !== 1'b1 && lim < 10) begin @(negedge clk); lim++; end
        check("n_done_cyc", cyc, w + 41);
        @(negedge clk);
        check("n_busy_after", {31'd0, n_tx_busy}, 32'd0);
    endtask

    initial begin
        int w;
        int d0;
        int rx0;
        int ov0;
        int lows;
        reset_n = 1'b0; baud_div = 16'd4; wr_en = 1'b0; wr_data = '0;
        baud_n = 16'd4; wr_en_n = 1'b0; wr_data_n = '0; parity_odd = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx_out",   {31'd0, tx_out},   32'd1);
        check("rst_busy",     {31'd0, tx_busy},  32'd0);
        check("rst_done",     {31'd0, tx_done},  32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_full",     {31'd0, full},     32'd0);
        check("rst_empty",    {31'd0, empty},    32'd1);
        check("rst_level",    {29'd0, level},    32'd0);
        check("rst_n_tx_out", {31'd0, n_tx_out}, 32'd1);
        check("rst_n_level",  {27'd0, n_level},  32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single byte 0x55, latency and frame timing; baud change mid-frame ignored
        mon_b = 4;
        d0 = done_q.size();
        sb_q.push_back(8'h55);
        wr_en = 1'b1; wr_data = 8'h55;
        @(negedge clk);
        wr_en = 1'b0;
        w = cyc;
        check("s1_empty_after_wr", {31'd0, empty}, 32'd0);
        check("s1_level_after_wr", {29'd0, level}, 32'd1);
        @(negedge clk);
        check("s1_empty_after_pop", {31'd0, empty}, 32'd1);
        check("s1_tx_idle_pop",     {31'd0, tx_out}, 32'd1);
        @(negedge clk);
        check("s1_tx_start", {31'd0, tx_out}, 32'd0);
        check("s1_busy",     {31'd0, tx_busy}, 32'd1);
        baud_div = 16'd6;
        wait_rx(1, 200);
        repeat (4) @(negedge clk);
        check("s1_start_cyc", start_cyc, w + 2);
        check("s1_done_count", done_q.size() - d0, 1);
        if (done_q.size() > d0) check("s1_done_cyc", done_q[d0], w + 41);
        check("s1_busy_fall", last_busy_fall, w + 42);
        baud_div = 16'd4;

        // Back-to-back frames
        d0 = done_q.size();
        sb_q.push_back(8'hA5); sb_q.push_back(8'h3C); sb_q.push_back(8'hFF);
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        w = cyc;
        check("b2b_level1", {29'd0, level}, 32'd1);
        wr_data = 8'h3C;
        @(negedge clk);
        wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        check("b2b_level2", {29'd0, level}, 32'd2);
        while (cyc < w + 80) @(negedge clk);
        check("b2b_level_before_3rd", {29'd0, level}, 32'd1);
        @(negedge clk);
        check("b2b_empty_after_3rd", {31'd0, empty}, 32'd1);
        wait_rx(4, 200);
        repeat (4) @(negedge clk);
        check("b2b_done_count", done_q.size() - d0, 3);
        if (done_q.size() >= d0 + 3) begin
            check("b2b_done0", done_q[d0], w + 41);
            check("b2b_gap1", done_q[d0 + 1] - done_q[d0], 40);
            check("b2b_gap2", done_q[d0 + 2] - done_q[d0 + 1], 40);
        end
        check("b2b_busy_fall", last_busy_fall, w + 122);

        // Overflow with DEPTH=4 while a frame is in flight
        sb_q.push_back(8'h11);
        wr_en = 1'b1; wr_data = 8'h11;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        ov0 = ov_cnt;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h21 + 8'(i);
            if (i < 4) sb_q.push_back(8'h21 + 8'(i));
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("ovf_full",  {31'd0, full},  32'd1);
        check("ovf_level", {29'd0, level}, 32'd4);
        @(negedge clk);
        check("ovf_pulses", ov_cnt - ov0, 2);
        wait_rx(9, 400);
        repeat (4) @(negedge clk);
        check("ovf_empty_end", {31'd0, empty}, 32'd1);

        // Divider values 0 and 1 behave as 2
        for (int v = 0; v < 2; v++) begin
            baud_div = 16'(v);
            mon_b = 2;
            d0 = done_q.size();
            rx0 = rx_cnt;
            sb_q.push_back(8'h3C ^ 8'(v));
            wr_en = 1'b1; wr_data = 8'h3C ^ 8'(v);
            @(negedge clk);
            wr_en = 1'b0;
            w = cyc;
            wait_rx(rx0 + 1, 100);
            repeat (4) @(negedge clk);
            check("clamp_start_cyc", start_cyc, w + 2);
            if (done_q.size() > d0) check("clamp_done_cyc", done_q[d0], w + 21);
            else check("clamp_done_count", done_q.size() - d0, 1);
        end
        baud_div = 16'd4;
        mon_b = 4;

        // 7 data bits, 2 stop bits
        narrow_frame(8'hFF);
        narrow_frame(8'hD5);

`ifdef UART_TX_PARITY_EN
        // Parity bit, even then odd
        for (int p = 0; p < 2; p++) begin
            parity_odd = 1'(p);
            d0 = done_q.size();
            rx0 = rx_cnt;
            sb_q.push_back(8'h07);
            wr_en = 1'b1; wr_data = 8'h07;
            @(negedge clk);
            wr_en = 1'b0;
            w = cyc;
            wait_rx(rx0 + 1, 200);
            repeat (8) @(negedge clk);
            if (done_q.size() > d0) check("par_done_cyc", done_q[d0], w + 45);
            else check("par_done_count", done_q.size() - d0, 1);
        end
        parity_odd = 1'b0;
`endif

        // Reset during data bit 3 of 0x81 with two bytes queued
        sb_q.push_back(8'h81); sb_q.push_back(8'h42); sb_q.push_back(8'h43);
        wr_en = 1'b1; wr_data = 8'h81;
        @(negedge clk);
        w = cyc;
        wr_data = 8'h42;
        @(negedge clk);
        wr_data = 8'h43;
        @(negedge clk);
        wr_en = 1'b0;
        while (cyc < w + 19) @(negedge clk);
        check("rstmid_bit3_low", {31'd0, tx_out}, 32'd0);
        check("rstmid_level",    {29'd0, level},  32'd2);
        #1 reset_n = 1'b0;
        #1;
        check("rstmid_tx_high", {31'd0, tx_out},  32'd1);
        check("rstmid_level0",  {29'd0, level},   32'd0);
        check("rstmid_empty",   {31'd0, empty},   32'd1);
        check("rstmid_busy",    {31'd0, tx_busy}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rx0 = rx_cnt;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_out !== 1'b1) lows++;
        end
        check("rstmid_line_quiet", lows, 0);
        check("rstmid_no_rx", rx_cnt, rx0);
        check("rstmid_still_empty", {31'd0, empty}, 32'd1);
        sb_q.push_back(8'h99);
        wr_en = 1'b1; wr_data = 8'h99;
        @(negedge clk);
        wr_en = 1'b0;
        wait_rx(rx0 + 1, 200);
        repeat (4) @(negedge clk);
        check("final_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised, FIFO-buffered UART transmitter for the ICE FPGA design. It accepts bytes from on-chip producers (host-command responses, MBus/GOC snoop traffic, bulk stimulus replay) and serialises them onto a single TX line with no inter-frame gaps. It supersedes the single-byte latch/empty handshake of the existing `uart` TX path with a configurable-depth queue, a configurable frame format and backpressure flags.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256
- DATA_BITS, 8, data bits per frame; 5..8
- STOP_BITS, 1, stop bits per frame; 1 or 2

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- baud_div  in  16  clock cycles per bit; values 0 and 1 are treated as 2
- wr_en  in  1  push wr_data into FIFO this cycle
- wr_data  in  8  byte to queue; bits above DATA_BITS-1 ignored
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  one-cycle pulse: write dropped because full
- tx_out  out  1  serial line, idle high
- tx_busy  out  1  frame in progress
- tx_done  out  1  one-cycle pulse at end of last stop bit
- parity_odd  in  1  only present with UART_TX_PARITY_EN; 1 = odd, 0 = even

## Operation
- FIFO: circular buffer, wr/rd pointers one bit wider than the address; full/empty from pointer compare; level = wr_ptr - rd_ptr.
- Write with full=1 is dropped and overflow pulses, even if a pop occurs the same cycle (full evaluated before pop).
- Write and pop in the same cycle when not full: both take effect; level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1; if empty=0, pop head into shift register, latch effective baud_div, go START.
  - START: tx_out=0 for one bit period, then DATA.
  - DATA: LSB first, DATA_BITS bit periods; then PARITY if enabled, else STOP.
  - PARITY: one bit period, tx_out = XOR of data bits XOR parity_odd.
  - STOP: tx_out=1 for STOP_BITS bit periods; at final cycle pulse tx_done; if empty=0 pop and go directly to START (no idle cycle), else IDLE.
- Bit timer: counts baud_div-1 down to 0 per bit; baud_div changes take effect only at the next frame load.
- tx_busy = 1 in every state except IDLE.
- tx_out registered; no glitches.

## Timing
- Reset values: tx_out=1, tx_busy=0, tx_done=0, overflow=0, full=0, empty=1, level=0; FSM IDLE; FIFO contents discarded.
- Reset asserted mid-frame: tx_out returns high asynchronously; frame aborted, queue flushed.
- Latency: wr_en at edge N into empty FIFO with FSM IDLE → empty=0 after edge N; pop at edge N+1; tx_out falls after edge N+2.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × baud_div cycles, P = 1 with parity else 0.
- Back-to-back frames: stop bit of frame k immediately followed by start bit of frame k+1; the pop occurs on the last stop-bit cycle.
- tx_done asserts in the last cycle of the final stop bit, concurrent with the next pop.

## Configuration
- UART_TX_PARITY_EN defined: parity_odd port exists, PARITY state inserted after DATA.
- Undefined: no parity_odd port, PARITY state unreachable/removed; frame = start + data + stop.

## Test plan
- Single byte: baud_div=4, DATA_BITS=8, write 0x55 → tx_out low after 2 cycles, then 0,1,0,1,0,1,0,1,0 + stop 1, each 4 cycles; tx_done pulses 40 cycles after start bit; tx_busy falls after.
- Back-to-back: write 0xA5,0x3C,0xFF in consecutive cycles → three 40-cycle frames with no idle between; three tx_done pulses 40 cycles apart; empty=1 after third pop.
- Overflow: DEPTH=4, FSM busy, write 6 bytes while one in flight → 4 accepted, full=1, two overflow pulses; transmitted order preserved.
- Parity (UART_TX_PARITY_EN, parity_odd=0): write 0x07 → parity bit 1; parity_odd=1 → parity bit 0; frame 44 cycles at baud_div=4.
- Narrow frame: DATA_BITS=7, STOP_BITS=2, write 0xFF → 7 data ones, two stop bits; 10 bit periods total.
- Reset mid-frame: assert reset_n=0 during bit 3 of 0x81 with 2 bytes queued → tx_out=1 immediately, level=0, empty=1; after release, no frame transmitted until new write.
